// File: rtl/id_ex_alu_issue_if.sv
// Issue-stage bus: upstream decode handshake plus the ALU-facing operand handshake.
interface id_ex_alu_issue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_rs1;
  logic [DATA_W-1:0] in_rs2;
  logic [IMM_W-1:0]  in_imm;
  logic              in_alu_src;
  logic [1:0]        in_alu_op;
  logic [5:0]        in_funct;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [3:0]        out_alu_ctrl;
  logic              out_illegal;

  // Producer of ops and consumer of ALU operands (decode + EX side).
  modport master (
    output in_valid, in_rs1, in_rs2, in_imm, in_alu_src, in_alu_op, in_funct, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_illegal
  );

  // The issue stage itself.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_imm, in_alu_src, in_alu_op, in_funct, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_illegal
  );
endinterface

// File: rtl/id_ex_alu_issue.sv
// ID->EX issue stage: decodes ALU control, selects operand B, and registers the op
// behind a valid/ready handshake with a main + skid register pair.
module id_ex_alu_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  id_ex_alu_issue_if.slave    bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic              accept;
  logic              load_main, load_skid, main_from_skid;

  logic [3:0]        dec_ctrl;
  logic              dec_ill;
  logic [DATA_W-1:0] dec_b;

  logic [DATA_W-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;
  logic [3:0]        main_ctrl_q, skid_ctrl_q;
  logic              main_ill_q, skid_ill_q;

  // Decode alu_op/funct into the ALU control code and pick operand B.
  always_comb begin
    dec_ctrl = 4'b0010;
    dec_ill  = 1'b0;
    unique case (bus.in_alu_op)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b10: begin
        case (bus.in_funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          default:   dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    dec_b = bus.in_alu_src ? {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm} : bus.in_rs2;
  end

  // An op offered during flush is dropped even if the handshake would complete.
  assign accept = bus.in_valid & in_ready_q & ~flush;

  // Occupancy FSM: decides next state and which register loads.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            load_main = 1'b1;
          end
        end
        StOne: begin
          if (accept && bus.out_ready) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = StTwo;
            load_skid = 1'b1;
          end else if (bus.out_ready) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (bus.out_ready) begin
            state_d        = StOne;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State register and registered in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StTwo);
    end
  end

  // Main (output) register: fresh op, or the older op promoted from skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_a_q    <= '0;
      main_b_q    <= '0;
      main_ctrl_q <= '0;
      main_ill_q  <= 1'b0;
    end else if (load_main) begin
      main_a_q    <= bus.in_rs1;
      main_b_q    <= dec_b;
      main_ctrl_q <= dec_ctrl;
      main_ill_q  <= dec_ill;
    end else if (main_from_skid) begin
      main_a_q    <= skid_a_q;
      main_b_q    <= skid_b_q;
      main_ctrl_q <= skid_ctrl_q;
      main_ill_q  <= skid_ill_q;
    end
  end

  // Skid register: catches the op accepted while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_a_q    <= '0;
      skid_b_q    <= '0;
      skid_ctrl_q <= '0;
      skid_ill_q  <= 1'b0;
    end else if (load_skid) begin
      skid_a_q    <= bus.in_rs1;
      skid_b_q    <= dec_b;
      skid_ctrl_q <= dec_ctrl;
      skid_ill_q  <= dec_ill;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = (state_q != StEmpty);
  assign bus.out_a        = main_a_q;
  assign bus.out_b        = main_b_q;
  assign bus.out_alu_ctrl = main_ctrl_q;
  assign bus.out_illegal  = main_ill_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for the ID->EX issue stage.
module tb_id_ex_alu_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  id_ex_alu_issue_if #(.DATA_W(32), .IMM_W(16)) bus ();

  id_ex_alu_issue #(.DATA_W(32), .IMM_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [15:0] imm,
                          input logic src, input logic [1:0] op, input logic [5:0] funct);
    bus.in_valid   = 1'b1;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_imm     = imm;
    bus.in_alu_src = src;
    bus.in_alu_op  = op;
    bus.in_funct   = funct;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive_op(32'd0, 32'd0, 16'd0, 1'b0, 2'b00, 6'd0);
    bus.in_valid = 1'b0;
    #12;
    tests++;
    if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_alu_ctrl, bus.out_illegal, bus.in_ready}
        !== {1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset: got v=%b a=%h b=%h c=%b i=%b rdy=%b, want v=0 a=0 b=0 c=0 i=0 rdy=1",
               bus.out_valid, bus.out_a, bus.out_b, bus.out_alu_ctrl, bus.out_illegal,
               bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    drive_op(32'd5, 32'd3, 16'd0, 1'b0, 2'b00, 6'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_alu_ctrl, bus.out_illegal}
        !== {1'b1, 32'd5, 32'd3, 4'b0010, 1'b0}) begin
      fails++;
      $display("FAIL add: got v=%b a=%h b=%h c=%b i=%b, want v=1 a=5 b=3 c=0010 i=0",
               bus.out_valid, bus.out_a, bus.out_b, bus.out_alu_ctrl, bus.out_illegal);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_drain: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_sext();
    logic [15:0] imms [2];
    logic [31:0] exps [2];
    imms[0] = 16'hFFFE; exps[0] = 32'hFFFF_FFFE;
    imms[1] = 16'h7FFF; exps[1] = 32'h0000_7FFF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_op(32'd9, 32'hDEAD_BEEF, imms[i], 1'b1, 2'b01, 6'd0);
      @(posedge clk);
      #1;
      tests++;
      if ({bus.out_valid, bus.out_b, bus.out_alu_ctrl} !== {1'b1, exps[i], 4'b0110}) begin
        fails++;
        $display("FAIL sext[%0d]: got v=%b b=%h c=%b, want v=1 b=%h c=0110", i,
                 bus.out_valid, bus.out_b, bus.out_alu_ctrl, exps[i]);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype();
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] ec;
    logic       ei;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op = 2'b10;
      case (i)
        0: begin fn = 6'b100000; ec = 4'b0010; ei = 1'b0; end
        1: begin fn = 6'b100010; ec = 4'b0110; ei = 1'b0; end
        2: begin fn = 6'b100100; ec = 4'b0000; ei = 1'b0; end
        3: begin fn = 6'b100101; ec = 4'b0001; ei = 1'b0; end
        4: begin fn = 6'b101010; ec = 4'b0111; ei = 1'b0; end
        5: begin fn = 6'b111111; ec = 4'b0010; ei = 1'b1; end
        default: begin op = 2'b11; fn = 6'b100100; ec = 4'b0010; ei = 1'b1; end
      endcase
      drive_op(32'd100 + i, 32'd7, 16'd0, 1'b0, op, fn);
      @(posedge clk);
      #1;
      tests++;
      if ({bus.out_valid, bus.out_a, bus.out_alu_ctrl, bus.out_illegal}
          !== {1'b1, 32'd100 + i, ec, ei}) begin
        fails++;
        $display("FAIL rtype[%0d]: got v=%b a=%0d c=%b i=%b, want v=1 a=%0d c=%b i=%b", i,
                 bus.out_valid, bus.out_a, bus.out_alu_ctrl, bus.out_illegal, 100 + i, ec, ei);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive_op(32'h11, 32'd0, 16'd0, 1'b0, 2'b00, 6'd0);   // X
    @(posedge clk);
    #1;
    drive_op(32'h22, 32'd0, 16'd0, 1'b0, 2'b00, 6'd0);   // Y
    tests++;
    if ({bus.out_valid, bus.out_a, bus.in_ready} !== {1'b1, 32'h11, 1'b1}) begin
      fails++;
      $display("FAIL b2b_x: got v=%b a=%h rdy=%b, want v=1 a=11 rdy=1",
               bus.out_valid, bus.out_a, bus.in_ready);
    end
    @(posedge clk);
    #1;
    drive_op(32'h33, 32'd0, 16'd0, 1'b0, 2'b00, 6'd0);   // Z
    tests++;
    if ({bus.out_valid, bus.out_a, bus.in_ready} !== {1'b1, 32'h11, 1'b0}) begin
      fails++;
      $display("FAIL b2b_full: got v=%b a=%h rdy=%b, want v=1 a=11 rdy=0",
               bus.out_valid, bus.out_a, bus.in_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({bus.out_valid, bus.out_a, bus.in_ready} !== {1'b1, 32'h11, 1'b0}) begin
      fails++;
      $display("FAIL b2b_hold: got v=%b a=%h rdy=%b, want v=1 a=11 rdy=0",
               bus.out_valid, bus.out_a, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({bus.out_valid, bus.out_a, bus.in_ready} !== {1'b1, 32'h22, 1'b1}) begin
      fails++;
      $display("FAIL b2b_y: got v=%b a=%h rdy=%b, want v=1 a=22 rdy=1",
               bus.out_valid, bus.out_a, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.out_valid, bus.out_a} !== {1'b1, 32'h33}) begin
      fails++;
      $display("FAIL b2b_z: got v=%b a=%h, want v=1 a=33", bus.out_valid, bus.out_a);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive_op(32'h41, 32'd0, 16'd0, 1'b0, 2'b00, 6'd0);
    @(posedge clk);
    #1;
    drive_op(32'h42, 32'd0, 16'd0, 1'b0, 2'b00, 6'd0);
    @(posedge clk);
    #1;
    // Buffer full; flush with a new op offered.
    drive_op(32'h4F, 32'd0, 16'd0, 1'b0, 2'b00, 6'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL flush_two: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    // One entry held, flush while in_ready=1 and an op is offered.
    drive_op(32'h51, 32'd0, 16'd0, 1'b0, 2'b00, 6'd0);
    @(posedge clk);
    #1;
    drive_op(32'h5F, 32'd0, 16'd0, 1'b0, 2'b00, 6'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL flush_one: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_drop: out_valid got %b (a=%h) want 0", bus.out_valid, bus.out_a);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive_op(32'h61, 32'h62, 16'd0, 1'b0, 2'b00, 6'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.out_valid, bus.out_a, bus.in_ready} !== {1'b0, 32'd0, 1'b1}) begin
      fails++;
      $display("FAIL async_rst: got v=%b a=%h rdy=%b, want v=0 a=0 rdy=1",
               bus.out_valid, bus.out_a, bus.in_ready);
    end
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    logic [36:0] q[$];
    logic [36:0] exp_e;
    logic [36:0] got;
    logic [31:0] rs1, rs2;
    logic [15:0] imm;
    logic        src;
    logic [1:0]  op;
    int          drain;
    for (int c = 0; c < 300; c++) begin
      rs1 = $urandom;
      rs2 = $urandom;
      imm = 16'($urandom);
      src = 1'($urandom);
      op  = 2'($urandom_range(0, 1));
      drive_op(rs1, rs2, imm, src, op, 6'd0);
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.out_a, bus.out_alu_ctrl, bus.out_illegal};
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra: unexpected op a=%h", bus.out_a);
        end else begin
          exp_e = q.pop_front();
          if (got !== exp_e) begin
            fails++;
            $display("FAIL stream_order: got %h want %h", got, exp_e);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back({rs1, (op == 2'b00) ? 4'b0010 : 4'b0110, 1'b0});
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain = 0;
    while (bus.out_valid && drain < 10) begin
      @(negedge clk);
      tests++;
      got = {bus.out_a, bus.out_alu_ctrl, bus.out_illegal};
      if (q.size() == 0) begin
        fails++;
        $display("FAIL stream_extra: unexpected op a=%h", bus.out_a);
      end else begin
        exp_e = q.pop_front();
        if (got !== exp_e) begin
          fails++;
          $display("FAIL stream_drain: got %h want %h", got, exp_e);
        end
      end
      @(posedge clk);
      #1;
      drain++;
    end
    tests++;
    if (bus.out_valid !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL stream_end: out_valid=%b leftover=%0d, want 0 and 0", bus.out_valid,
               q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sext();
    test_rtype();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
